// File: rtl/cdr_link_supervisor.sv
// Link supervisor for the Manchester CDR receive path: sequences CDR reset and
// acquisition, qualifies lock, polices the bit rate and retrains with backoff.
module cdr_link_supervisor #(
    parameter int HOLD_CYCLES  = 8,
    parameter int LOCK_TIMEOUT = 1024,
    parameter int STABLE_BITS  = 64,
    parameter int BACKOFF_BASE = 16,
    parameter int MAX_RETRY    = 4,
    parameter int RATE_WINDOW  = 256,
    parameter int RATE_MIN     = 60,
    parameter int RATE_MAX     = 68
) (
    input  logic       clk_link,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       fault_clr,
    input  logic       cdr_locked,
    input  logic       cdr_bit_valid,
    output logic       cdr_rst_n,
    output logic       link_up,
    output logic       fault,
    output logic [2:0] state,
    output logic [2:0] retry_cnt,
    output logic [7:0] loss_cnt,
    output logic       rate_err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RESET   = 3'd1,
        S_ACQUIRE = 3'd2,
        S_QUALIFY = 3'd3,
        S_UP      = 3'd4,
        S_BACKOFF = 3'd5,
        S_FAULT   = 3'd6
    } state_t;

    localparam int BACKOFF_MAX = BACKOFF_BASE << (MAX_RETRY - 1);
    localparam int T_AB   = (LOCK_TIMEOUT > BACKOFF_MAX) ? LOCK_TIMEOUT : BACKOFF_MAX;
    localparam int T_SPAN = (T_AB > HOLD_CYCLES) ? T_AB : HOLD_CYCLES;
    localparam int TW     = $clog2(T_SPAN + 1);
    localparam int B_SPAN = (STABLE_BITS > RATE_WINDOW) ? STABLE_BITS : RATE_WINDOW;
    localparam int BW     = $clog2(B_SPAN + 1);
    localparam int WW     = (RATE_WINDOW > 1) ? $clog2(RATE_WINDOW) : 1;

    localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LAST   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [BW-1:0] STABLE_LAST = BW'(STABLE_BITS - 1);
    localparam logic [WW-1:0] WIN_LAST    = WW'(RATE_WINDOW - 1);
    localparam logic [BW:0]   CNT_MIN     = (BW + 1)'(RATE_MIN);
    localparam logic [BW:0]   CNT_MAX     = (BW + 1)'(RATE_MAX);
    localparam logic [2:0]    RETRY_LAST  = 3'(MAX_RETRY - 1);
    localparam logic [2:0]    RETRY_FULL  = 3'(MAX_RETRY);

    state_t        state_q;
    logic [TW-1:0] timer;
    logic [BW-1:0] bit_cnt;
    logic [WW-1:0] win;

    logic [TW-1:0] backoff_last;
    logic [BW:0]   win_total;
    logic          win_last;
    logic          rate_bad;
    logic          fail_acq;
    logic          fail_qual;
    logic          failure;

    assign backoff_last = TW'((BACKOFF_BASE << retry_cnt) - 1);

    // the strobe on the final window cycle still belongs to this window
    assign win_total = {1'b0, bit_cnt} + {{BW{1'b0}}, cdr_bit_valid};
    assign win_last  = (win == WIN_LAST);
    assign rate_bad  = (win_total < CNT_MIN) || (win_total > CNT_MAX);

    assign fail_acq  = (state_q == S_ACQUIRE) && !cdr_locked
                       && (timer == LOCK_LAST);
    assign fail_qual = (state_q == S_QUALIFY) && !cdr_locked;
    assign failure   = fail_acq || fail_qual;

    always_ff @(posedge clk_link or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            timer     <= '0;
            bit_cnt   <= '0;
            win       <= '0;
            retry_cnt <= '0;
            loss_cnt  <= '0;
            rate_err  <= 1'b0;
        end else begin
            rate_err <= 1'b0;
            if (!enable) begin
                state_q   <= S_IDLE;
                timer     <= '0;
                bit_cnt   <= '0;
                win       <= '0;
                retry_cnt <= '0;
            end else if ((state_q == S_FAULT) && fault_clr) begin
                state_q   <= S_RESET;
                timer     <= '0;
                retry_cnt <= '0;
            end else if (failure) begin
                timer <= '0;
                if (retry_cnt == RETRY_LAST) begin
                    state_q   <= S_FAULT;
                    retry_cnt <= RETRY_FULL;
                end else begin
                    state_q <= S_BACKOFF;
                end
            end else begin
                case (state_q)
                    S_IDLE: begin
                        state_q <= S_RESET;
                        timer   <= '0;
                    end
                    S_RESET: begin
                        if (timer == HOLD_LAST) begin
                            state_q <= S_ACQUIRE;
                            timer   <= '0;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    S_ACQUIRE: begin
                        if (cdr_locked) begin
                            state_q <= S_QUALIFY;
                            bit_cnt <= '0;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    S_QUALIFY: begin
                        if (cdr_bit_valid) begin
                            if (bit_cnt == STABLE_LAST) begin
                                state_q   <= S_UP;
                                retry_cnt <= '0;
                                bit_cnt   <= '0;
                                win       <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + BW'(1);
                            end
                        end
                    end
                    S_UP: begin
                        // lock loss wins over a coincident rate failure
                        if (!cdr_locked || (win_last && rate_bad)) begin
                            state_q  <= S_RESET;
                            timer    <= '0;
                            rate_err <= cdr_locked;
                            if (loss_cnt != 8'hFF) begin
                                loss_cnt <= loss_cnt + 8'd1;
                            end
                        end else if (win_last) begin
                            win     <= '0;
                            bit_cnt <= '0;
                        end else begin
                            win     <= win + WW'(1);
                            bit_cnt <= bit_cnt + {{(BW-1){1'b0}}, cdr_bit_valid};
                        end
                    end
                    S_BACKOFF: begin
                        if (timer == backoff_last) begin
                            state_q   <= S_RESET;
                            timer     <= '0;
                            retry_cnt <= retry_cnt + 3'd1;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    S_FAULT: begin
                        state_q <= S_FAULT;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        timer   <= '0;
                    end
                endcase
            end
        end
    end

    assign state     = state_q;
    assign cdr_rst_n = (state_q == S_ACQUIRE) || (state_q == S_QUALIFY)
                       || (state_q == S_UP);
    assign link_up   = (state_q == S_UP);
    assign fault     = (state_q == S_FAULT);

endmodule

// File: tb/tb_cdr_link_supervisor.sv
// Bench for cdr_link_supervisor: directed vector table, corner sequences and
// random stimulus against a cycle-level behavioural model.
module tb_cdr_link_supervisor;

    localparam int HOLD    = 8;
    localparam int LOCK_TO = 1024;
    localparam int STABLE  = 64;
    localparam int BB      = 16;
    localparam int MAXR    = 4;
    localparam int WIN     = 256;
    localparam int RMIN    = 60;
    localparam int RMAX    = 68;

    localparam int M_IDLE = 0, M_RESET = 1, M_ACQ = 2, M_QUAL = 3;
    localparam int M_UP = 4, M_BACKOFF = 5, M_FAULT = 6;

    logic       clk_link = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       fault_clr;
    logic       cdr_locked;
    logic       cdr_bit_valid;
    logic       cdr_rst_n;
    logic       link_up;
    logic       fault;
    logic [2:0] state;
    logic [2:0] retry_cnt;
    logic [7:0] loss_cnt;
    logic       rate_err;

    cdr_link_supervisor #(
        .HOLD_CYCLES(HOLD), .LOCK_TIMEOUT(LOCK_TO), .STABLE_BITS(STABLE),
        .BACKOFF_BASE(BB), .MAX_RETRY(MAXR), .RATE_WINDOW(WIN),
        .RATE_MIN(RMIN), .RATE_MAX(RMAX)
    ) dut (
        .clk_link(clk_link), .rst_n(rst_n), .enable(enable),
        .fault_clr(fault_clr), .cdr_locked(cdr_locked),
        .cdr_bit_valid(cdr_bit_valid), .cdr_rst_n(cdr_rst_n),
        .link_up(link_up), .fault(fault), .state(state),
        .retry_cnt(retry_cnt), .loss_cnt(loss_cnt), .rate_err(rate_err)
    );

    always #5 clk_link = ~clk_link;

    typedef struct {
        int n; int en; int clr; int lk; int nb;
        int st; int rn; int lu; int fl; int re; int rc; int lc;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_model_msgs = 0;
    int   cyc = 0;

    int m_state, m_age, m_bits, m_retry, m_loss, m_rerr;

    function automatic void model_reset();
        m_state = M_IDLE; m_age = 0; m_bits = 0;
        m_retry = 0; m_loss = 0; m_rerr = 0;
    endfunction

    function automatic void go(int s);
        m_state = s; m_age = 0; m_bits = 0;
    endfunction

    function automatic void m_fail();
        if (m_retry == MAXR - 1) begin
            m_retry = MAXR;
            go(M_FAULT);
        end else begin
            go(M_BACKOFF);
        end
    endfunction

    // state-residency view: age = cycles spent in the current state
    function automatic void model_step(int en, int clr, int lk, int bv);
        int win_end;
        int bad;
        m_rerr = 0;
        if (en == 0) begin
            go(M_IDLE);
            m_retry = 0;
        end else if (m_state == M_FAULT && clr != 0) begin
            go(M_RESET);
            m_retry = 0;
        end else begin
            case (m_state)
                M_IDLE: go(M_RESET);
                M_RESET: if (m_age + 1 == HOLD) go(M_ACQ); else m_age++;
                M_ACQ: begin
                    if (lk != 0) go(M_QUAL);
                    else if (m_age + 1 == LOCK_TO) m_fail();
                    else m_age++;
                end
                M_QUAL: begin
                    if (lk == 0) m_fail();
                    else begin
                        m_bits += bv;
                        if (m_bits == STABLE) begin
                            go(M_UP);
                            m_retry = 0;
                        end
                    end
                end
                M_UP: begin
                    m_bits += bv;
                    win_end = ((m_age % WIN) == WIN - 1) ? 1 : 0;
                    bad = (win_end != 0 && (m_bits < RMIN || m_bits > RMAX)) ? 1 : 0;
                    if (lk == 0 || bad != 0) begin
                        if (m_loss < 255) m_loss++;
                        m_rerr = (lk != 0) ? 1 : 0;
                        go(M_RESET);
                    end else begin
                        m_age++;
                        if (win_end != 0) m_bits = 0;
                    end
                end
                M_BACKOFF: begin
                    if (m_age + 1 == BB * (2 ** m_retry)) begin
                        m_retry++;
                        go(M_RESET);
                    end else begin
                        m_age++;
                    end
                end
                default: ;
            endcase
        end
    endfunction

    function automatic void check_model();
        int ern, elu, efl;
        bit ok;
        ern = (m_state == M_ACQ || m_state == M_QUAL || m_state == M_UP) ? 1 : 0;
        elu = (m_state == M_UP) ? 1 : 0;
        efl = (m_state == M_FAULT) ? 1 : 0;
        ok = (int'(state) == m_state) && (int'(cdr_rst_n) == ern)
             && (int'(link_up) == elu) && (int'(fault) == efl)
             && (int'(retry_cnt) == m_retry) && (int'(loss_cnt) == m_loss)
             && (int'(rate_err) == m_rerr);
        n_checks++;
        if (!ok) begin
            n_fail++;
            n_model_msgs++;
            if (n_model_msgs <= 30)
                $display("FAIL model cyc=%0d got st=%0d rn=%0d lu=%0d flt=%0d rc=%0d lc=%0d re=%0d want st=%0d rn=%0d lu=%0d flt=%0d rc=%0d lc=%0d re=%0d",
                         cyc, state, cdr_rst_n, link_up, fault, retry_cnt,
                         loss_cnt, rate_err, m_state, ern, elu, efl, m_retry,
                         m_loss, m_rerr);
        end
    endfunction

    function automatic void chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endfunction

    function automatic void check_vec(int r);
        bit ok;
        ok = (int'(state) == tbl[r].st) && (int'(cdr_rst_n) == tbl[r].rn)
             && (int'(link_up) == tbl[r].lu) && (int'(fault) == tbl[r].fl)
             && (int'(rate_err) == tbl[r].re) && (int'(retry_cnt) == tbl[r].rc)
             && (int'(loss_cnt) == tbl[r].lc);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL vec%0d got st=%0d rn=%0d lu=%0d flt=%0d re=%0d rc=%0d lc=%0d want st=%0d rn=%0d lu=%0d flt=%0d re=%0d rc=%0d lc=%0d",
                     r, state, cdr_rst_n, link_up, fault, rate_err, retry_cnt,
                     loss_cnt, tbl[r].st, tbl[r].rn, tbl[r].lu, tbl[r].fl,
                     tbl[r].re, tbl[r].rc, tbl[r].lc);
        end
    endfunction

    task automatic step(input int en, input int clr, input int lk, input int bv);
        enable        = (en != 0);
        fault_clr     = (clr != 0);
        cdr_locked    = (lk != 0);
        cdr_bit_valid = (bv != 0);
        @(posedge clk_link);
        model_step(en, clr, lk, bv);
        cyc++;
        #1;
        check_model();
    endtask

    task automatic wait_up(input string name);
        bit got;
        got = 0;
        for (int c = 0; c < 300 && !got; c++) begin
            step(1, 0, 1, 1);
            if (state == 3'd4) got = 1;
        end
        chk(name, int'(got), 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bo[$];
        int exp_bo[3];
        int run;
        int mode;
        int en, clr, lk, bv;

        // n  en clr lk nb    st rn lu fl re rc lc
        tbl.push_back('{1,   1, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{7,   1, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{1,   1, 0, 0, 0,   2, 1, 0, 0, 0, 0, 0});
        tbl.push_back('{11,  1, 0, 0, 0,   2, 1, 0, 0, 0, 0, 0});
        tbl.push_back('{1,   1, 0, 1, 0,   3, 1, 0, 0, 0, 0, 0});
        tbl.push_back('{252, 1, 0, 1, 63,  3, 1, 0, 0, 0, 0, 0});
        tbl.push_back('{4,   1, 0, 1, 1,   4, 1, 1, 0, 0, 0, 0});
        tbl.push_back('{256, 1, 0, 1, 64,  4, 1, 1, 0, 0, 0, 0});
        tbl.push_back('{256, 1, 0, 1, 68,  4, 1, 1, 0, 0, 0, 0});
        tbl.push_back('{256, 1, 0, 1, 58,  1, 0, 0, 0, 1, 0, 1});
        tbl.push_back('{1,   1, 0, 0, 0,   1, 0, 0, 0, 0, 0, 1});
        tbl.push_back('{7,   1, 0, 1, 0,   2, 1, 0, 0, 0, 0, 1});
        tbl.push_back('{1,   1, 0, 1, 0,   3, 1, 0, 0, 0, 0, 1});
        tbl.push_back('{256, 1, 0, 1, 64,  4, 1, 1, 0, 0, 0, 1});
        tbl.push_back('{256, 1, 0, 1, 69,  1, 0, 0, 0, 1, 0, 2});
        tbl.push_back('{8,   1, 0, 1, 0,   2, 1, 0, 0, 0, 0, 2});
        tbl.push_back('{1,   1, 0, 1, 0,   3, 1, 0, 0, 0, 0, 2});
        tbl.push_back('{64,  1, 0, 1, 64,  4, 1, 1, 0, 0, 0, 2});
        tbl.push_back('{255, 1, 0, 1, 70,  4, 1, 1, 0, 0, 0, 2});
        tbl.push_back('{1,   1, 0, 0, 1,   1, 0, 0, 0, 0, 0, 3});
        tbl.push_back('{8,   1, 0, 1, 0,   2, 1, 0, 0, 0, 0, 3});
        tbl.push_back('{1,   1, 0, 1, 0,   3, 1, 0, 0, 0, 0, 3});
        tbl.push_back('{10,  1, 0, 1, 3,   3, 1, 0, 0, 0, 0, 3});
        tbl.push_back('{1,   1, 0, 0, 0,   5, 0, 0, 0, 0, 0, 3});
        tbl.push_back('{15,  1, 0, 0, 0,   5, 0, 0, 0, 0, 0, 3});
        tbl.push_back('{1,   1, 0, 0, 0,   1, 0, 0, 0, 0, 1, 3});
        tbl.push_back('{8,   1, 0, 1, 0,   2, 1, 0, 0, 0, 1, 3});
        tbl.push_back('{1,   1, 0, 1, 0,   3, 1, 0, 0, 0, 1, 3});
        tbl.push_back('{1,   1, 0, 0, 0,   5, 0, 0, 0, 0, 1, 3});
        tbl.push_back('{10,  1, 0, 0, 0,   5, 0, 0, 0, 0, 1, 3});
        tbl.push_back('{1,   0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 3});
        tbl.push_back('{1,   1, 0, 0, 0,   1, 0, 0, 0, 0, 0, 3});
        tbl.push_back('{8,   1, 0, 1, 0,   2, 1, 0, 0, 0, 0, 3});
        tbl.push_back('{1,   1, 0, 1, 0,   3, 1, 0, 0, 0, 0, 3});
        tbl.push_back('{64,  1, 0, 1, 64,  4, 1, 1, 0, 0, 0, 3});
        tbl.push_back('{1,   1, 0, 0, 0,   1, 0, 0, 0, 0, 0, 4});
        tbl.push_back('{7,   1, 0, 1, 0,   1, 0, 0, 0, 0, 0, 4});
        tbl.push_back('{1,   1, 0, 1, 0,   2, 1, 0, 0, 0, 0, 4});
        exp_bo[0] = 16;
        exp_bo[1] = 32;
        exp_bo[2] = 64;

        rst_n = 1'b0;
        enable = 1'b1;
        fault_clr = 1'b0;
        cdr_locked = 1'b1;
        cdr_bit_valid = 1'b1;
        model_reset();
        repeat (3) @(posedge clk_link);
        #1;
        chk("rst_state", int'(state), 0);
        chk("rst_cdr_rst_n", int'(cdr_rst_n), 0);
        chk("rst_link_up", int'(link_up), 0);
        chk("rst_fault", int'(fault), 0);
        chk("rst_rate_err", int'(rate_err), 0);
        chk("rst_retry", int'(retry_cnt), 0);
        chk("rst_loss", int'(loss_cnt), 0);
        rst_n = 1'b1;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        for (int r = 0; r < tbl.size(); r++) begin
            for (int i = 0; i < tbl[r].n; i++) begin
                bv = (((i + 1) * tbl[r].nb) / tbl[r].n > (i * tbl[r].nb) / tbl[r].n) ? 1 : 0;
                step(tbl[r].en, tbl[r].clr, tbl[r].lk, bv);
            end
            check_vec(r);
        end

        step(0, 0, 0, 0);
        run = 0;
        for (int i = 0; i < 4240; i++) begin
            step(1, 0, 0, 0);
            if (state == 3'd5) run++;
            else if (run != 0) begin
                bo.push_back(run);
                run = 0;
            end
        end
        chk("nolock_prefault_fault", int'(fault), 0);
        chk("nolock_prefault_state", int'(state), 2);
        step(1, 0, 0, 0);
        chk("nolock_fault", int'(fault), 1);
        chk("nolock_retry", int'(retry_cnt), 4);
        chk("backoff_count", bo.size(), 3);
        for (int i = 0; i < 3 && i < bo.size(); i++)
            chk($sformatf("backoff_len%0d", i), bo[i], exp_bo[i]);
        repeat (5) step(1, 0, 0, 0);
        chk("fault_sticky", int'(state), 6);
        step(1, 1, 0, 0);
        chk("fault_clr_state", int'(state), 1);
        chk("fault_clr_retry", int'(retry_cnt), 0);

        for (int k = 0; k < 300; k++) begin
            wait_up("sat_wait_up");
            step(1, 0, 0, 0);
        end
        chk("loss_saturated", int'(loss_cnt), 255);
        chk("loss_link_down", int'(link_up), 0);

        wait_up("async_wait_up");
        repeat (5) step(1, 0, 1, 0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_state", int'(state), 0);
        chk("async_link_up", int'(link_up), 0);
        chk("async_cdr_rst_n", int'(cdr_rst_n), 0);
        chk("async_loss", int'(loss_cnt), 0);
        model_reset();
        repeat (2) @(posedge clk_link);
        #1;
        chk("async_hold_state", int'(state), 0);
        rst_n = 1'b1;
        step(1, 0, 1, 0);
        chk("async_restart", int'(state), 1);

        mode = 0;
        for (int i = 0; i < 20000; i++) begin
            if (i % 1500 == 0) mode = $urandom_range(0, 2);
            en  = ($urandom_range(0, 799) != 0) ? 1 : 0;
            clr = ($urandom_range(0, 29) == 0) ? 1 : 0;
            case (mode)
                0: lk = ($urandom_range(0, 699) != 0) ? 1 : 0;
                1: lk = $urandom_range(0, 1);
                default: lk = 0;
            endcase
            bv = ($urandom_range(0, 3) == 0) ? 1 : 0;
            step(en, clr, lk, bv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cdr_link_supervisor.md
# cdr_link_supervisor

Link-level controller for the 200 MHz Manchester CDR receive path. It sequences CDR reset and acquisition, then qualifies lock by counting recovered bits. It monitors the recovered bit rate while the link is up and retrains with exponential backoff after failures. It sits between the CDR and the frame/packet layer, which uses `link_up` as its receive enable.

## Interface
Parameters:
- `HOLD_CYCLES`, 8: width of the CDR reset pulse, in cycles.
- `LOCK_TIMEOUT`, 1024: cycles allowed in ACQUIRE for `cdr_locked` to rise.
- `STABLE_BITS`, 64: `cdr_bit_valid` pulses required in QUALIFY before link up.
- `BACKOFF_BASE`, 16: first backoff length, in cycles; it doubles per retry.
- `MAX_RETRY`, 4: consecutive acquisition failures that cause FAULT (1..7).
- `RATE_WINDOW`, 256: rate-check window, in cycles (nominal 64 bits at 4x).
- `RATE_MIN`, 60 / `RATE_MAX`, 68: inclusive legal bit count per window.

Ports:
- `clk_link` in 1: 200 MHz link clock; the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: link enable; low forces IDLE.
- `fault_clr` in 1: in FAULT, restarts acquisition.
- `cdr_locked` in 1: CDR lock status.
- `cdr_bit_valid` in 1: one-cycle recovered-bit strobe.
- `cdr_rst_n` out 1: active-low reset to the CDR.
- `link_up` out 1: link qualified and healthy.
- `fault` out 1: retries exhausted.
- `state` out 3: current state encoding.
- `retry_cnt` out 3: consecutive failure count.
- `loss_cnt` out 8: count of drops from UP; saturates at 255.
- `rate_err` out 1: one-cycle pulse on a rate-window violation.

## Operation
- State encodings: IDLE=0, RESET=1, ACQUIRE=2, QUALIFY=3, UP=4, BACKOFF=5, FAULT=6. Codes 7 and any illegal value go to IDLE.
- Moore outputs are decoded from registered state only, with no combinational input-to-output path.
  - `cdr_rst_n`=1 only in ACQUIRE, QUALIFY and UP.
  - `link_up`=1 only in UP.
  - `fault`=1 only in FAULT.
- Priority order, highest first: `enable`=0, then `fault_clr` in FAULT, then the per-state rules below.
- `enable`=0 in any state: next state is IDLE, and the timer, bit counter and `retry_cnt` are cleared. `loss_cnt` is kept.
- IDLE: `enable`=1 moves to RESET with the timer cleared.
- RESET: stays exactly `HOLD_CYCLES` cycles, then moves to ACQUIRE with the timer cleared.
- ACQUIRE:
  - `cdr_locked`=1 moves to QUALIFY with the bit counter cleared.
  - If the timer reaches `LOCK_TIMEOUT`-1 with no lock, a failure occurs.
- QUALIFY:
  - Counts `cdr_bit_valid` pulses.
  - `cdr_locked`=0 is a failure.
  - The `STABLE_BITS`-th pulse moves to UP and clears `retry_cnt`.
- UP:
  - A window counter runs 0..`RATE_WINDOW`-1 and counts `cdr_bit_valid`; a pulse on the last window cycle is included.
  - At the last window cycle, a count outside [`RATE_MIN`,`RATE_MAX`] pulses `rate_err`, increments `loss_cnt` and moves to RESET.
  - `cdr_locked`=0 increments `loss_cnt` and moves to RESET.
  - If lock is lost and the rate check fails in the same cycle, the event counts once and `rate_err` is not pulsed.
  - `retry_cnt` is not incremented on exits from UP.
- Failure handling:
  - If `retry_cnt`==`MAX_RETRY`-1: set `retry_cnt`=`MAX_RETRY` and move to FAULT.
  - Otherwise: move to BACKOFF for `BACKOFF_BASE`<<`retry_cnt` cycles (using the pre-increment value), then increment `retry_cnt`.
- BACKOFF: holds the CDR in reset, then moves to RESET.
- FAULT: sticky. `fault_clr`=1 moves to RESET with `retry_cnt`=0. `enable`=0 moves to IDLE.
- Width rules: the timer is sized for max(`LOCK_TIMEOUT`, `BACKOFF_BASE`<<(`MAX_RETRY`-1), `HOLD_CYCLES`). `loss_cnt` saturates at 255 and does not wrap.

## Timing
- During reset: state=IDLE, `cdr_rst_n`=0, `link_up`=0, `fault`=0, `rate_err`=0, `retry_cnt`=0, `loss_cnt`=0.
- Let N be the edge at which `enable`=1 is sampled in IDLE:
  - State is RESET from N+1.
  - `cdr_rst_n` rises at N+1+`HOLD_CYCLES`.
- When `cdr_locked` is sampled high in ACQUIRE at edge M, state is QUALIFY at M+1.
- When the `STABLE_BITS`-th `cdr_bit_valid` is sampled at edge K, `link_up`=1 from K+1.
- After a loss or rate error sampled at edge L:
  - `link_up`=0 and `cdr_rst_n`=0 from L+1.
  - `rate_err` is high for cycle L+1 only.
- Reset deasserting mid-operation restarts from IDLE. No partial state survives.

## Test plan
- Nominal bring-up: reset release, `enable`=1 at edge 0, lock at edge 20, `cdr_bit_valid` every 4 cycles.
  - Required: `cdr_rst_n` low for edges 1..8 and high at 9.
  - Required: `link_up` rises the cycle after the 64th strobe, and `retry_cnt`=0.
- Never lock: hold `cdr_locked`=0.
  - Required: backoffs of 16, 32 and 64 cycles.
  - Required: `fault`=1 and `retry_cnt`=4 at edge 4241 after enable was sampled.
  - Then pulse `fault_clr` → state RESET, `retry_cnt`=0.
- Lock loss in UP: drop `cdr_locked` for 1 cycle.
  - Required: `link_up`=0 next cycle, `loss_cnt` goes 0→1, then RESET for 8 cycles.
  - Repeat 300 times → `loss_cnt` holds at 255.
- Rate error: in UP, give 58 strobes in a 256-cycle window.
  - Required: a single `rate_err` pulse, and `loss_cnt` increments once.
  - Required: 68 strobes gives no error; 69 gives an error.
- Simultaneous events and dropout:
  - Lock loss on the last window cycle with a bad count → `loss_cnt` +1 only, no `rate_err`.
  - Lock drops mid-QUALIFY → BACKOFF of 16 cycles, `retry_cnt`=1.
- Enable/reset override:
  - `enable`=0 mid-BACKOFF → IDLE next cycle, `retry_cnt`=0.
  - Asserting `rst_n` mid-UP asynchronously forces all outputs to their reset values.
